icache_responder: RTL and testbench

Direct-mapped instruction cache that answers the fetch stage's PC lookups combinationally and refills lines from the memory side on a miss. Fetch drives PC and consumes hit/instruction, holding its PC until hit. This block owns the miss FSM, line refill, invalidation (fence.i) and the fetch-fault indication.

---
 rtl/icache_responder.sv | 182 ++++++++++++++++++
 tb/tb_icache_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: combinational hit path plus a single-line refill FSM.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters on PERF_HITS/PERF_MISSES.
module icache_responder #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] FE_PC,
  input  logic        FE_REQ,
  input  logic        FLUSH,
  output logic        CACHE_HIT,
  output logic [31:0] INSTRUCTION,
  output logic        ICACHE_FAULT,
  output logic        ICACHE_BUSY,
  output logic        MEM_REQ,
  output logic [63:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ERR,
  output logic [31:0] PERF_HITS,
  output logic [31:0] PERF_MISSES
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = 2 + WORD_W;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;
  localparam int LINE_W = 64 - OFF_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              flushed_q, flushed_d;
  logic              fault_q, fault_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [31:0]       data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q [LINES];
  logic              data_we;
  logic              tag_we;

  logic [IDX_W-1:0]  fe_idx;
  logic [TAG_W-1:0]  fe_tag;
  logic [WORD_W-1:0] fe_word;
  logic [IDX_W-1:0]  line_idx;
  logic [TAG_W-1:0]  line_tag;
  logic              aligned;
  logic              hit;
  logic              fault_match;

  assign fe_idx   = FE_PC[OFF_W +: IDX_W];
  assign fe_tag   = FE_PC[63 -: TAG_W];
  assign fe_word  = FE_PC[2 +: WORD_W];
  assign line_idx = line_q[IDX_W-1:0];
  assign line_tag = line_q[LINE_W-1 -: TAG_W];
  assign aligned  = (FE_PC[1:0] == 2'b00);

  assign hit         = FE_REQ & aligned & valid_q[fe_idx] & (tag_q[fe_idx] == fe_tag);
  assign fault_match = fault_q & (FE_PC[63:OFF_W] == line_q) & (state_q == IDLE);

  assign CACHE_HIT    = hit;
  assign INSTRUCTION  = data_q[fe_idx][fe_word];
  assign ICACHE_FAULT = fault_match;
  assign ICACHE_BUSY  = (state_q != IDLE);
  assign MEM_REQ      = (state_q == REQ);
  assign MEM_ADDR     = {line_q, {OFF_W{1'b0}}};

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    flushed_d = flushed_q;
    fault_d   = fault_q;
    valid_d   = valid_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;

    case (state_q)
      IDLE: begin
        // A faulted line is not retried until the fetch stage moves away or flushes.
        if (!FLUSH && FE_REQ && aligned && !hit && !fault_match) begin
          line_d          = FE_PC[63:OFF_W];
          valid_d[fe_idx] = 1'b0;
          fault_d         = 1'b0;
          err_d           = 1'b0;
          flushed_d       = 1'b0;
          state_d         = REQ;
        end
      end
      REQ: begin
        if (MEM_GNT) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (MEM_RVALID) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (MEM_ERR) err_d = 1'b1;
          if (cnt_q == WORD_W'(LINE_WORDS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!err_q && !flushed_q) begin
          tag_we            = 1'b1;
          valid_d[line_idx] = 1'b1;
        end
        if (err_q) fault_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any validation above; a refill in flight drains but stays invalid.
    if (FLUSH) begin
      valid_d = '0;
      fault_d = 1'b0;
      if (state_q != IDLE) flushed_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      line_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
      fault_q   <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      flushed_q <= flushed_d;
      fault_q   <= fault_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (data_we) data_q[line_idx][cnt_q] <= MEM_RDATA;
    if (tag_we) tag_q[line_idx] <= line_tag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (hit && (perf_hits_q != 32'hFFFF_FFFF)) perf_hits_d = perf_hits_q + 32'd1;
    if ((state_q == IDLE) && (state_d == REQ) && (perf_misses_q != 32'hFFFF_FFFF))
      perf_misses_d = perf_misses_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign PERF_HITS   = perf_hits_q;
  assign PERF_MISSES = perf_misses_q;
`else
  assign PERF_HITS   = '0;
  assign PERF_MISSES = '0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized fetch traffic
// checked against a line-level cache model (valid/tag per index, fault line, hit/miss counts).
module tb_icache_responder;
  localparam int LW = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] FE_PC;
  logic        FE_REQ;
  logic        FLUSH;
  logic        CACHE_HIT;
  logic [31:0] INSTRUCTION;
  logic        ICACHE_FAULT;
  logic        ICACHE_BUSY;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        MEM_ERR;
  logic [31:0] PERF_HITS;
  logic [31:0] PERF_MISSES;

  int tests = 0;
  int failures = 0;

  // Reference model: one entry per cache index, plus the faulted line and event counts.
  bit          m_valid [64];
  logic [63:0] m_tag [64];
  bit          m_fault_valid;
  logic [63:0] m_fault_line;
  logic [63:0] m_line;
  int unsigned m_hits;
  int unsigned m_misses;

  icache_responder dut (
    .CLK(CLK), .RESET(RESET), .FE_PC(FE_PC), .FE_REQ(FE_REQ), .FLUSH(FLUSH),
    .CACHE_HIT(CACHE_HIT), .INSTRUCTION(INSTRUCTION), .ICACHE_FAULT(ICACHE_FAULT),
    .ICACHE_BUSY(ICACHE_BUSY), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .MEM_ERR(MEM_ERR),
    .PERF_HITS(PERF_HITS), .PERF_MISSES(PERF_MISSES)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Backing memory contents: 0x1000 -> 0x13, 0x1004 -> 0x93, ...
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return 32'h13 + ((lo - 32'h1000) << 5);
  endfunction

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 4) % 64);
  endfunction

  function automatic bit model_hit(input logic [63:0] pc, input logic req);
    return req && ((pc % 4) == 0) && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 10));
  endfunction

  function automatic bit model_fault(input logic [63:0] pc);
    return m_fault_valid && ((pc >> 4) == m_fault_line);
  endfunction

  task automatic model_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_fault_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h, expected %h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic req, input logic flush);
    FE_PC  = pc;
    FE_REQ = req;
    FLUSH  = flush;
  endtask

  // phase: 0 idle, 1 request, 2 fill, 3 done
  task automatic check_lookup(input int phase);
    bit eh;
    eh = model_hit(FE_PC, FE_REQ);
    checkOutput("cache_hit", {63'd0, CACHE_HIT}, {63'd0, eh});
    if (eh) begin
      checkOutput("instruction", {32'd0, INSTRUCTION}, {32'd0, mem_word(FE_PC)});
      m_hits++;
    end
    checkOutput("icache_fault", {63'd0, ICACHE_FAULT}, {63'd0, (phase == 0) && model_fault(FE_PC)});
    checkOutput("icache_busy", {63'd0, ICACHE_BUSY}, {63'd0, phase != 0});
    checkOutput("mem_req", {63'd0, MEM_REQ}, {63'd0, phase == 1});
    if (phase == 1) checkOutput("mem_addr", MEM_ADDR, m_line << 4);
  endtask

  task automatic step(input int phase);
    @(negedge CLK);
    check_lookup(phase);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    applyStimulus(64'd0, 1'b0, 1'b0);
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_flush();
    m_hits = 0; m_misses = 0; m_line = 64'd0;
  endtask

  task automatic check_perf(input int unsigned hits, input int unsigned misses);
`ifdef ICACHE_PERF_CNT_EN
    checkOutput("perf_hits", {32'd0, PERF_HITS}, {32'd0, hits});
    checkOutput("perf_misses", {32'd0, PERF_MISSES}, {32'd0, misses});
`else
    checkOutput("perf_hits", {32'd0, PERF_HITS}, 64'd0 & {32'd0, hits});
    checkOutput("perf_misses", {32'd0, PERF_MISSES}, 64'd0 & {32'd0, misses});
`endif
  endtask

  // Full miss/refill sequence for pc; err_beat/flush_beat < 0 disables that event.
  task automatic refill(input logic [63:0] pc, input int err_beat, input int flush_beat,
                        input logic [63:0] probe);
    logic [63:0] line;
    int beat, gaps, waits;
    bit err, flushed;
    line = pc & ~64'hF;
    applyStimulus(pc, 1'b1, 1'b0);
    step(0);
    m_valid[idx_of(pc)] = 1'b0;
    m_fault_valid = 1'b0;
    m_misses++;
    m_line = pc >> 4;

    waits = $urandom_range(0, 2);
    for (int i = 0; i < waits; i++) begin
      MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
      step(1);
    end
    MEM_RVALID = 1'b0; MEM_GNT = 1'b1;
    step(1);
    MEM_GNT = 1'b0;

    beat = 0; gaps = 0; err = 1'b0; flushed = 1'b0;
    while (beat < LW) begin
      if (gaps < 3 && $urandom_range(0, 2) == 0) begin
        gaps++;
        MEM_RVALID = 1'b0; MEM_ERR = 1'b0; FLUSH = 1'b0; FE_PC = probe;
        step(2);
      end else begin
        FE_PC = pc; MEM_RVALID = 1'b1; MEM_RDATA = mem_word(line + 64'(4 * beat));
        MEM_ERR = (beat == err_beat); FLUSH = (beat == flush_beat);
        step(2);
        if (MEM_ERR) err = 1'b1;
        if (FLUSH) begin model_flush(); flushed = 1'b1; end
        beat++;
      end
    end
    MEM_ERR = 1'b0; FLUSH = 1'b0;

    FE_PC = pc; MEM_RVALID = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    step(3);
    MEM_RVALID = 1'b0;
    if (err) begin
      m_fault_valid = 1'b1;
      m_fault_line  = pc >> 4;
    end else if (!flushed) begin
      m_valid[idx_of(pc)] = 1'b1;
      m_tag[idx_of(pc)]   = pc >> 10;
    end
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] probe;
    logic req;
    int r, eb, fb;

    // Reset state
    do_reset();
    checkOutput("reset_mem_addr", MEM_ADDR, 64'd0);
    check_perf(0, 0);
    step(0);

    // Cold miss at 0x1000 then five hit cycles
    refill(64'h1000, -1, -1, 64'h1000);
    applyStimulus(64'h1000, 1'b1, 1'b0); step(0);
    applyStimulus(64'h100C, 1'b1, 1'b0); step(0);
    applyStimulus(64'h1004, 1'b1, 1'b0); step(0);
    applyStimulus(64'h1008, 1'b1, 1'b0); step(0);
    applyStimulus(64'h1000, 1'b1, 1'b0); step(0);
    check_perf(5, 1);

    // Conflict eviction: 0x1400 shares the index of 0x1000
    refill(64'h1400, -1, -1, 64'h1000);
    applyStimulus(64'h1404, 1'b1, 1'b0); step(0);
    refill(64'h1000, -1, -1, 64'h1400);
    applyStimulus(64'h1000, 1'b1, 1'b0); step(0);

    // Misaligned fetch neither hits nor refills
    applyStimulus(64'h1002, 1'b1, 1'b0); step(0);
    step(0);

    // Error beat: line faults, no retry while fetch stays on it
    refill(64'h2000, 2, -1, 64'h1000);
    applyStimulus(64'h2000, 1'b1, 1'b0); step(0);
    applyStimulus(64'h2004, 1'b1, 1'b0); step(0);
    applyStimulus(64'h200C, 1'b1, 1'b0); step(0);
    applyStimulus(64'h3000, 1'b0, 1'b0); step(0);
    applyStimulus(64'h2008, 1'b0, 1'b0); step(0);

    // Flush in the middle of a fill
    refill(64'h1010, -1, -1, 64'h2000);
    refill(64'h1020, -1, -1, 64'h1010);
    refill(64'h1030, -1, 2, 64'h1010);
    refill(64'h1010, -1, -1, 64'h1020);

    // Flush in idle, and flush colliding with a miss
    refill(64'h1030, -1, -1, 64'h1010);
    applyStimulus(64'h1030, 1'b1, 1'b1); step(0); model_flush();
    applyStimulus(64'h1040, 1'b1, 1'b1); step(0); model_flush();
    applyStimulus(64'h1040, 1'b0, 1'b0); step(0);
    refill(64'h1030, -1, -1, 64'h1010);

    // Reset in the middle of a refill; late beats are ignored
    applyStimulus(64'h1050, 1'b1, 1'b0); step(0);
    m_valid[idx_of(64'h1050)] = 1'b0; m_fault_valid = 1'b0; m_misses++; m_line = 64'h105;
    MEM_GNT = 1'b1; step(1); MEM_GNT = 1'b0;
    MEM_RVALID = 1'b1; MEM_RDATA = $urandom; step(2);
    RESET = 1'b1; FE_REQ = 1'b0; step(2);
    RESET = 1'b0;
    model_flush(); m_hits = 0; m_misses = 0; m_line = 64'd0;
    checkOutput("midreset_mem_addr", MEM_ADDR, 64'd0);
    check_perf(0, 0);
    step(0);
    MEM_RDATA = $urandom; step(0);
    MEM_RVALID = 1'b0;
    refill(64'h1050, -1, -1, 64'h1000);
    applyStimulus(64'h1058, 1'b1, 1'b0); step(0);

    // Randomized fetch traffic over aliasing lines
    for (int it = 0; it < 60; it++) begin
      pc = 64'h1000 + 64'($urandom_range(0, 11) + 64 * $urandom_range(0, 1)) * 16
           + 64'($urandom_range(0, 3)) * 4;
      if ($urandom_range(0, 9) == 0) pc = pc + 64'd1;
      probe = 64'h1000 + 64'($urandom_range(0, 11) + 64 * $urandom_range(0, 1)) * 16;
      req = ($urandom_range(0, 5) != 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        applyStimulus(pc, req, 1'b1); step(0); model_flush();
      end else if (req && (pc % 4) == 0 && !model_hit(pc, 1'b1) && !model_fault(pc)) begin
        eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        fb = (eb < 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
        refill(pc, eb, fb, probe);
      end else begin
        applyStimulus(pc, req, 1'b0); step(0);
      end
    end

    check_perf(m_hits, m_misses);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
